sdr_sdram_model: RTL and testbench
==================================

// Module: sdr_sdram_model
// PURPOSE
//  Synthesizable single-data-rate SDRAM device model for emulation; stands in for the
//  mt48lc2m32b2 / IS42VM16400K / mt48lc8m8a2 devices on the sdram_bus side of sdrc_top.
//  Decodes JEDEC SDR commands, tracks open rows per bank, stores data in on-chip
//  memory, and returns read bursts at the programmed CAS latency.
// PARAMETERS
//  SDR_DW     16  DQ width in bits (8/16/32)
//  SDR_BW     2   byte lanes = SDR_DW/8 (DQM width)
//  ROW_W      4   modelled row-address bits (low bits of sdr_addr used)
//  COL_W      8   column-address bits (CFG_COLBITS=00 -> 8)
//  ADDR_W     13  sdr_addr width
// PORTS
//  sdram_clk    in   1        clock; all state changes on rising edge
//  sdram_rst    in   1        synchronous active-high reset
//  sdr_cs_n     in   1        chip select, low active
//  sdr_ras_n    in   1        row strobe
//  sdr_cas_n    in   1        column strobe
//  sdr_we_n     in   1        write enable
//  sdr_ba       in   2        bank address
//  sdr_addr     in   ADDR_W   row/column/mode address
//  sdr_dqm      in   SDR_BW   byte mask, 1 = masked
//  sdr_dq_i     in   SDR_DW   write data from controller
//  sdr_dq_o     out  SDR_DW   read data to controller
//  sdr_dq_oe    out  1        1 = model drives DQ
//  model_err    out  1        sticky protocol-error flag
// BEHAVIOUR
//  Reset: sdr_dq_o=0, sdr_dq_oe=0, model_err=0, all banks closed, mode BL=1 CL=3,
//   burst counters idle. Memory contents are not cleared by reset.
//  Command decode when cs_n=0 {ras,cas,we}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE,
//   010 PRECHARGE (A10=1 all banks), 001 AUTO-REFRESH, 000 LOAD MODE, 110 BURST-STOP.
//   cs_n=1 = NOP.
//  LOAD MODE: BL from addr[2:0] (000=1,001=2,010=4,011=8; other codes -> 8); CL from
//   addr[6:4] (010=2, 011=3; other codes -> 3, model_err set). Accepted only when all
//   banks are idle, else model_err set and the mode is unchanged.
//  ACTIVE: opens row addr[ROW_W-1:0] in bank ba. ACTIVE to an open bank sets model_err
//   and the new row replaces the old one.
//  PRECHARGE closes the bank(s). AUTO-REFRESH with any bank open sets model_err;
//   otherwise it is a no-op.
//  Word address = {ba, row[ba], col}; memory depth 2^(2+ROW_W+COL_W) words of SDR_DW.
//  WRITE (bank open): beat 0 takes sdr_dq_i in the command cycle; beats 1..BL-1 follow
//   on consecutive cycles. Column increments sequentially and wraps within the
//   BL-aligned block (col[log2BL-1:0] wraps, upper column bits fixed). Byte lane k is
//   written only if sdr_dqm[k]=0 in that beat's cycle.
//  READ (bank open): beat i is driven in cycle C+CL+i (C = command cycle); oe=1 exactly
//   for those BL cycles. Read DQM masking has 2-cycle latency: a masked beat drives
//   oe=0 for that beat.
//  READ or WRITE to a closed bank: model_err set, no data transfer.
//  Interrupts: a new READ/WRITE terminates the current burst at its issue cycle (read
//   data already in the CL pipe still drains up to the new command's first beat).
//   BURST-STOP or PRECHARGE ends the burst; outstanding read beats already in the CL
//   pipe still complete. Write followed immediately by read on the same address
//   returns the new data.
//  sdram_rst mid-burst: abort all bursts, oe=0 on the next edge, banks closed.
//  model_err stays set until sdram_rst.
// TESTING
//  LOAD MODE addr=0x032 (CL3,BL4); ACTIVE b1 row 3; WRITE col 0x10 data 0x1111..0x4444
//   -> READ col 0x10: oe high cycles C+3..C+6, data 0x1111,0x2222,0x3333,0x4444.
//  BL4 WRITE at col 0x06 -> beats land at cols 6,7,4,5 (wrap in block); read back matches.
//  WRITE 0xABCD with dqm=2'b10 over 0xFFFF -> read returns 0xFFCD.
//  CL2 mode (0x022): READ -> first beat in C+2; READ interrupted after 2 cycles by a
//   new READ -> clean switch to the new burst, no oe gap.
//  READ to a closed bank, or ACTIVE to an open bank -> model_err=1 and stays 1 until
//   sdram_rst; no DQ drive.
//  Assert sdram_rst during a BL8 read -> oe=0 next cycle, model_err=0, banks closed.

Source files
------------

// File: rtl/sdr_sdram_model_if.sv
// SDR SDRAM device-side bus: controller (master) drives command/address/write data,
// the device model (slave) returns read data, output enable and its error flag.
interface sdr_sdram_model_if #(
    parameter int unsigned SDR_DW = 16,
    parameter int unsigned SDR_BW = 2,
    parameter int unsigned ADDR_W = 13
);
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [1:0]        sdr_ba;
    logic [ADDR_W-1:0] sdr_addr;
    logic [SDR_BW-1:0] sdr_dqm;
    logic [SDR_DW-1:0] sdr_dq_i;
    logic [SDR_DW-1:0] sdr_dq_o;
    logic              sdr_dq_oe;
    logic              model_err;

    modport master (
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, sdr_dqm, sdr_dq_i,
        input  sdr_dq_o, sdr_dq_oe, model_err
    );

    modport slave (
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, sdr_dqm, sdr_dq_i,
        output sdr_dq_o, sdr_dq_oe, model_err
    );
endinterface

// File: rtl/sdr_sdram_model.sv
// Synthesizable SDR SDRAM device model: JEDEC command decode, per-bank open-row tracking,
// on-chip storage, write bursts with DQM, read bursts at CL2/CL3 with 2-cycle read DQM.
module sdr_sdram_model #(
    parameter int unsigned SDR_DW = 16,
    parameter int unsigned SDR_BW = 2,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned COL_W  = 8,
    parameter int unsigned ADDR_W = 13
) (
    input logic               sdram_clk,
    input logic               sdram_rst,
    sdr_sdram_model_if.slave  sdr
);
    localparam int unsigned AW    = 2 + ROW_W + COL_W;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    logic [SDR_DW-1:0] mem [DEPTH];

    logic [3:0]        bank_open;
    logic [ROW_W-1:0]  bank_row [4];
    logic [3:0]        bl_len;
    logic              cl3;

    logic [2:0]        rd_left, wr_left;
    logic [1:0]        rd_ba, wr_ba;
    logic [ROW_W-1:0]  rd_row, wr_row;
    logic [COL_W-1:0]  rd_col, wr_col;

    logic              p0_vld, p1_vld;
    logic [SDR_DW-1:0] p0_data, p1_data;
    logic [SDR_BW-1:0] dqm_q;

    cmd_e              cmd_c;
    logic [1:0]        cmd_ba_c;
    logic [COL_W-1:0]  cmd_col_c, col_mask_c;
    logic              open_c, stop_c;
    logic              rd_start_c, wr_start_c, rd_go_c, wr_go_c;
    logic [AW-1:0]     rd_addr_c, wr_addr_c;
    logic              err_set_c, lmr_ok_c, new_cl3_c;
    logic [3:0]        new_bl_c;
    logic              sel_vld_c;
    logic [SDR_DW-1:0] sel_data_c;
    logic              unused_addr_c;

    // Sequential column advance that wraps inside the BL-aligned block.
    function automatic logic [COL_W-1:0] wrap_col(input logic [COL_W-1:0] col,
                                                  input logic [COL_W-1:0] mask);
        return (col & ~mask) | ((col + COL_W'(1)) & mask);
    endfunction

    assign cmd_c      = sdr.sdr_cs_n ? CMD_NOP : cmd_e'({sdr.sdr_ras_n, sdr.sdr_cas_n, sdr.sdr_we_n});
    assign cmd_ba_c   = sdr.sdr_ba;
    assign cmd_col_c  = sdr.sdr_addr[COL_W-1:0];
    assign col_mask_c = COL_W'(bl_len - 4'd1);
    assign open_c     = bank_open[cmd_ba_c];
    assign stop_c     = (cmd_c == CMD_RD) || (cmd_c == CMD_WR) ||
                        (cmd_c == CMD_BST) || (cmd_c == CMD_PRE);

    assign rd_start_c = (cmd_c == CMD_RD) && open_c;
    assign wr_start_c = (cmd_c == CMD_WR) && open_c;
    assign rd_go_c    = !sdram_rst && (rd_start_c || ((rd_left != 3'd0) && !stop_c));
    assign wr_go_c    = !sdram_rst && (wr_start_c || ((wr_left != 3'd0) && !stop_c));
    assign rd_addr_c  = rd_start_c ? {cmd_ba_c, bank_row[cmd_ba_c], cmd_col_c} : {rd_ba, rd_row, rd_col};
    assign wr_addr_c  = wr_start_c ? {cmd_ba_c, bank_row[cmd_ba_c], cmd_col_c} : {wr_ba, wr_row, wr_col};

    assign sel_vld_c  = cl3 ? p1_vld  : p0_vld;
    assign sel_data_c = cl3 ? p1_data : p0_data;

    assign unused_addr_c = ^sdr.sdr_addr;

    // Protocol checks and mode-register decode.
    always_comb begin
        err_set_c = 1'b0;
        lmr_ok_c  = 1'b0;
        new_bl_c  = bl_len;
        new_cl3_c = cl3;
        case (cmd_c)
            CMD_ACT:         err_set_c = open_c;
            CMD_RD, CMD_WR:  err_set_c = !open_c;
            CMD_REF:         err_set_c = |bank_open;
            CMD_LMR: begin
                if (|bank_open) begin
                    err_set_c = 1'b1;
                end else begin
                    lmr_ok_c = 1'b1;
                    case (sdr.sdr_addr[2:0])
                        3'b000:  new_bl_c = 4'd1;
                        3'b001:  new_bl_c = 4'd2;
                        3'b010:  new_bl_c = 4'd4;
                        default: new_bl_c = 4'd8;
                    endcase
                    case (sdr.sdr_addr[6:4])
                        3'b010:  new_cl3_c = 1'b0;
                        3'b011:  new_cl3_c = 1'b1;
                        default: begin
                            new_cl3_c = 1'b1;
                            err_set_c = 1'b1;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Storage: not cleared by reset; read port feeds the CL pipe.
    always_ff @(posedge sdram_clk) begin
        p0_data <= mem[rd_addr_c];
        if (wr_go_c) begin
            for (int unsigned k = 0; k < SDR_BW; k++) begin
                if (!sdr.sdr_dqm[k]) mem[wr_addr_c][k*8 +: 8] <= sdr.sdr_dq_i[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            bank_open     <= '0;
            for (int i = 0; i < 4; i++) bank_row[i] <= '0;
            bl_len        <= 4'd1;
            cl3           <= 1'b1;
            sdr.model_err <= 1'b0;
            rd_left       <= '0;
            wr_left       <= '0;
            rd_ba         <= '0;
            wr_ba         <= '0;
            rd_row        <= '0;
            wr_row        <= '0;
            rd_col        <= '0;
            wr_col        <= '0;
            p0_vld        <= 1'b0;
            p1_vld        <= 1'b0;
            p1_data       <= '0;
            dqm_q         <= '0;
            sdr.sdr_dq_o  <= '0;
            sdr.sdr_dq_oe <= 1'b0;
        end else begin
            sdr.model_err <= sdr.model_err | err_set_c;
            if (lmr_ok_c) begin
                bl_len <= new_bl_c;
                cl3    <= new_cl3_c;
            end
            if (cmd_c == CMD_ACT) begin
                bank_open[cmd_ba_c] <= 1'b1;
                bank_row[cmd_ba_c]  <= sdr.sdr_addr[ROW_W-1:0];
            end else if (cmd_c == CMD_PRE) begin
                if (sdr.sdr_addr[10]) bank_open <= '0;
                else                  bank_open[cmd_ba_c] <= 1'b0;
            end

            // Read burst cursor: a new command or stop truncates the running burst.
            if (rd_start_c) begin
                rd_ba   <= cmd_ba_c;
                rd_row  <= bank_row[cmd_ba_c];
                rd_col  <= wrap_col(cmd_col_c, col_mask_c);
                rd_left <= 3'(bl_len - 4'd1);
            end else if (stop_c) begin
                rd_left <= '0;
            end else if (rd_left != 3'd0) begin
                rd_col  <= wrap_col(rd_col, col_mask_c);
                rd_left <= rd_left - 3'd1;
            end

            if (wr_start_c) begin
                wr_ba   <= cmd_ba_c;
                wr_row  <= bank_row[cmd_ba_c];
                wr_col  <= wrap_col(cmd_col_c, col_mask_c);
                wr_left <= 3'(bl_len - 4'd1);
            end else if (stop_c) begin
                wr_left <= '0;
            end else if (wr_left != 3'd0) begin
                wr_col  <= wrap_col(wr_col, col_mask_c);
                wr_left <= wr_left - 3'd1;
            end

            // CL pipe; dqm_q gives the two-cycle read-mask latency.
            p0_vld        <= rd_go_c;
            p1_vld        <= p0_vld;
            p1_data       <= p0_data;
            dqm_q         <= sdr.sdr_dqm;
            sdr.sdr_dq_oe <= sel_vld_c && !(&dqm_q);
            sdr.sdr_dq_o  <= sel_vld_c ? sel_data_c : '0;
        end
    end
endmodule

// File: tb/tb_sdr_sdram_model.sv
// Directed bench for sdr_sdram_model: mode load, bursts, wrap, DQM, CL2 interrupt,
// protocol errors and mid-burst reset, with immediate assertions at each check.
module tb_sdr_sdram_model;
    localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] irq_exp [9];

    always #5 clk = ~clk;

    sdr_sdram_model_if sdr_if ();

    sdr_sdram_model dut (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .sdr       (sdr_if)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] m, input logic [15:0] d);
        sdr_if.sdr_cs_n = 1'b0;
        {sdr_if.sdr_ras_n, sdr_if.sdr_cas_n, sdr_if.sdr_we_n} = c;
        sdr_if.sdr_ba   = ba;
        sdr_if.sdr_addr = a;
        sdr_if.sdr_dqm  = m;
        sdr_if.sdr_dq_i = d;
    endtask

    // Inputs change on the falling edge; outputs read there belong to the current cycle.
    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        drive(c, ba, a, m, d);
    endtask

    task automatic nop();
        issue(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    endtask

    task automatic beat(input string tag, input logic exp_oe, input logic [15:0] exp_d);
        check({tag, "_oe"}, 16'(sdr_if.sdr_dq_oe), 16'(exp_oe));
        if (exp_oe) check({tag, "_dq"}, sdr_if.sdr_dq_o, exp_d);
    endtask

    task automatic write_bl4(input logic [1:0] ba, input logic [12:0] col,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input logic [1:0] m0, input logic [1:0] m1,
                             input logic [1:0] m2, input logic [1:0] m3);
        issue(C_WR,  ba,   col,   m0, d0);
        issue(C_NOP, 2'd0, 13'h0, m1, d1);
        issue(C_NOP, 2'd0, 13'h0, m2, d2);
        issue(C_NOP, 2'd0, 13'h0, m3, d3);
        nop();
    endtask

    // BL4 read: beat i expected in cycle C+cl+i, oe low one cycle either side.
    task automatic read_bl4(input string tag, input logic [1:0] ba, input logic [12:0] col,
                            input int cl, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        issue(C_RD, ba, col, 2'b00, 16'h0);
        for (int j = 1; j <= cl + 4; j++) begin
            nop();
            if (j >= cl && j < cl + 4) beat($sformatf("%s_j%0d", tag, j), 1'b1, e[j-cl]);
            else                       beat($sformatf("%s_j%0d", tag, j), 1'b0, 16'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        sdr_if.sdr_cs_n = 1'b1;
        drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_oe",  16'(sdr_if.sdr_dq_oe), 16'h0);
        check("rst_dq",  sdr_if.sdr_dq_o,       16'h0);
        check("rst_err", 16'(sdr_if.model_err), 16'h0);

        // CL3 BL4, bank 1 row 3
        issue(C_LMR, 2'd0, 13'h032, 2'b00, 16'h0);
        issue(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
        write_bl4(2'd1, 13'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b00, 2'b00, 2'b00, 2'b00);
        read_bl4("rd_cl3", 2'd1, 13'h010, 3, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // Wrap within BL-aligned block: beats land at cols 6,7,4,5
        write_bl4(2'd1, 13'h006, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 2'b00, 2'b00, 2'b00, 2'b00);
        read_bl4("wrap", 2'd1, 13'h004, 3, 16'hA002, 16'hA003, 16'hA000, 16'hA001);

        // Write byte mask
        write_bl4(2'd1, 13'h020, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 2'b00, 2'b00);
        write_bl4(2'd1, 13'h020, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b11, 2'b11, 2'b11);
        read_bl4("wmask", 2'd1, 13'h020, 3, 16'hFFCD, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Read DQM in cycle C+1 suppresses the beat of cycle C+3
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        issue(C_NOP, 2'd0, 13'h0, 2'b11, 16'h0);
        beat("rmask_j1", 1'b0, 16'h0);
        nop(); beat("rmask_j2", 1'b0, 16'h0);
        nop(); beat("rmask_j3", 1'b0, 16'h0);
        nop(); beat("rmask_j4", 1'b1, 16'h2222);
        nop(); beat("rmask_j5", 1'b1, 16'h3333);
        nop(); beat("rmask_j6", 1'b1, 16'h4444);
        nop(); beat("rmask_j7", 1'b0, 16'h0);

        // Write then read immediately at the same address
        issue(C_WR, 2'd1, 13'h030, 2'b00, 16'h5555);
        issue(C_RD, 2'd1, 13'h030, 2'b00, 16'h0);
        nop(); nop(); beat("raw_j2", 1'b0, 16'h0);
        nop(); beat("raw_j3", 1'b1, 16'h5555);
        repeat (4) nop();
        check("err_clean", 16'(sdr_if.model_err), 16'h0);

        // CL2 BL4
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_LMR, 2'd0, 13'h022, 2'b00, 16'h0);
        issue(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
        read_bl4("rd_cl2", 2'd1, 13'h010, 2, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // READ interrupted by READ at C+2: no gap, new burst from C+4
        irq_exp[0] = 16'h0;    irq_exp[1] = 16'h0;    irq_exp[2] = 16'h1111;
        irq_exp[3] = 16'h2222; irq_exp[4] = 16'hA002; irq_exp[5] = 16'hA003;
        irq_exp[6] = 16'hA000; irq_exp[7] = 16'hA001; irq_exp[8] = 16'h0;
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        for (int j = 1; j <= 8; j++) begin
            if (j == 2) issue(C_RD, 2'd1, 13'h004, 2'b00, 16'h0);
            else        nop();
            beat($sformatf("irq_j%0d", j), (j >= 2 && j <= 7), irq_exp[j]);
        end

        // BURST-STOP at C+1 leaves only the beat already in the pipe
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        issue(C_BST, 2'd0, 13'h0, 2'b00, 16'h0);
        nop(); beat("bst_j2", 1'b1, 16'h1111);
        nop(); beat("bst_j3", 1'b0, 16'h0);
        nop(); beat("bst_j4", 1'b0, 16'h0);
        check("err_before_closed", 16'(sdr_if.model_err), 16'h0);

        // READ to a closed bank: sticky error, no DQ drive
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        for (int j = 1; j <= 5; j++) begin
            nop();
            check($sformatf("closed_err_j%0d", j), 16'(sdr_if.model_err), 16'h1);
            beat($sformatf("closed_j%0d", j), 1'b0, 16'h0);
        end

        // Reset clears error; mode back to BL1 CL3, memory retained
        @(negedge clk); rst = 1'b1; drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        @(negedge clk); rst = 1'b0;
        check("rst2_err", 16'(sdr_if.model_err), 16'h0);
        issue(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        nop(); nop(); beat("bl1_j2", 1'b0, 16'h0);
        nop(); beat("bl1_j3", 1'b1, 16'h1111);
        nop(); beat("bl1_j4", 1'b0, 16'h0);
        check("bl1_err", 16'(sdr_if.model_err), 16'h0);

        // ACTIVE to an open bank
        issue(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
        nop();
        check("act_open_err", 16'(sdr_if.model_err), 16'h1);

        // Reset during a BL8 read
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_LMR, 2'd0, 13'h033, 2'b00, 16'h0);
        issue(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        nop(); nop(); nop(); beat("bl8_j3", 1'b1, 16'h1111);
        nop(); beat("bl8_j4", 1'b1, 16'h2222);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_oe",  16'(sdr_if.sdr_dq_oe), 16'h0);
        check("midrst_err", 16'(sdr_if.model_err), 16'h0);
        nop(); beat("midrst_j6", 1'b0, 16'h0);
        issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
        nop();
        check("banks_closed_err", 16'(sdr_if.model_err), 16'h1);
        nop(); nop(); beat("banks_closed_j3", 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
